dual_issue_ctrl: RTL and testbench

- Issue stage directly downstream of the frontend's decoded-instruction FIFO.
- Each cycle it inspects up to two head instructions (slot 0 = older) and decides how many to pop: 0, 1 or 2.
- Issued instructions are registered into a two-lane issue latch that feeds the execute pipes.
- Keeps a register-busy scoreboard for long-latency producers (load, mul, div).

---
 rtl/issue_pkg.sv | 44 ++++
 rtl/issue_scoreboard.sv | 60 ++++++
 rtl/dual_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_dual_issue_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and decode helpers for the dual-issue stage.
// Holds the instruction format, the issue class enum and the register-zero constant.
package issue_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [3:0] {
        OpNop, OpAdd, OpLd, OpSt, OpMul, OpDiv, OpBr, OpJmp, OpCsr, OpBar, OpIdle, OpErtn
    } op_t;

    typedef enum logic [2:0] {
        InstAlu, InstMem, InstBr, InstMulDiv, InstPriv
    } inst_class_t;

    typedef struct packed {
        op_t                  op;
        logic [1:0][REG_W-1:0] r_reg;
        logic [REG_W-1:0]      w_reg;
    } decode_info_t;

    typedef struct packed {
        logic [31:0]  pc;
        decode_info_t info;
    } inst_t;

    function automatic inst_class_t get_inst_class(decode_info_t di);
        inst_class_t cls;
        case (di.op)
            OpLd, OpSt:                      cls = InstMem;
            OpBr, OpJmp:                     cls = InstBr;
            OpMul, OpDiv:                    cls = InstMulDiv;
            OpCsr, OpBar, OpIdle, OpErtn:    cls = InstPriv;
            default:                         cls = InstAlu;
        endcase
        return cls;
    endfunction

    // Stores also classify as MEM, but carry w_reg == 0 so they never mark a register.
    function automatic logic is_long_latency(inst_class_t cls);
        return (cls == InstMem) || (cls == InstMulDiv);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register-busy scoreboard for long-latency producers.
// Busy queries see same-cycle writeback clears so a waiting consumer can issue on the wb cycle.
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int unsigned NUM_WB_PORTS = 2,
    parameter int unsigned REG_NUM      = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush_i,
    input  logic [1:0]                          set_valid_i,
    input  logic [1:0][REG_W-1:0]               set_reg_i,
    input  logic [NUM_WB_PORTS-1:0]             wb_valid_i,
    input  logic [NUM_WB_PORTS-1:0][REG_W-1:0]  wb_reg_i,
    input  logic [1:0][2:0][REG_W-1:0]          query_reg_i,
    output logic [1:0][2:0]                     query_busy_o
);

    logic [REG_NUM-1:0] busy_q, busy_d;
    logic [REG_NUM-1:0] clr_vec, set_vec, busy_eff;

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            for (int k = 0; k < NUM_WB_PORTS; k++) begin
                if (wb_valid_i[k] && wb_reg_i[k] == REG_W'(r)) clr_vec[r] = 1'b1;
            end
            for (int s = 0; s < 2; s++) begin
                if (set_valid_i[s] && set_reg_i[s] == REG_W'(r)) set_vec[r] = 1'b1;
            end
        end
    end

    assign busy_eff = busy_q & ~clr_vec;

    // Set applied after clear: a newly issued producer is younger than the writeback.
    always_comb begin
        busy_d = busy_eff | set_vec;
        if (flush_i) busy_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        query_busy_o = '0;
        for (int s = 0; s < 2; s++) begin
            for (int q = 0; q < 3; q++) begin
                for (int r = 1; r < REG_NUM; r++) begin
                    if (query_reg_i[s][q] == REG_W'(r)) query_busy_o[s][q] = busy_eff[r];
                end
            end
        end
    end

endmodule

// File: rtl/dual_issue_ctrl.sv
// In-order dual-issue stage: picks 0/1/2 FIFO heads and registers them into the issue latch.
// Define ISSUE_PERF_CNT_EN to add saturating dual/single/zero issue counters on perf_cnt_o.
module dual_issue_ctrl
    import issue_pkg::*;
#(
    parameter int unsigned NUM_WB_PORTS = 2,
    parameter int unsigned REG_NUM      = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  inst_t [1:0]                         inst_i,
    input  logic [1:0]                          inst_valid_i,
    output logic [1:0]                          issue_num_o,
    output logic                                backend_stall_o,
    input  logic                                flush_i,
    input  logic                                exe_ready_i,
    input  logic [NUM_WB_PORTS-1:0]             wb_valid_i,
    input  logic [NUM_WB_PORTS-1:0][REG_W-1:0]  wb_reg_i,
    output inst_t [1:0]                         issue_inst_o,
`ifdef ISSUE_PERF_CNT_EN
    output logic [2:0][31:0]                    perf_cnt_o,
`endif
    output logic [1:0]                          issue_valid_o
);

    inst_t [1:0]      inst_q;
    logic [1:0]       valid_q;
    inst_class_t      cls0, cls1;
    logic [1:0][2:0][REG_W-1:0] query_reg;
    logic [1:0][2:0]  query_busy;
    logic [1:0]       hz;
    logic             can_accept;
    logic             raw, waw, pair_ok;
    logic             slot0_iss, slot1_iss;
    logic [1:0]       set_valid;
    logic [1:0][REG_W-1:0] set_reg;

    assign cls0 = get_inst_class(inst_i[0].info);
    assign cls1 = get_inst_class(inst_i[1].info);

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            query_reg[s][0] = inst_i[s].info.r_reg[0];
            query_reg[s][1] = inst_i[s].info.r_reg[1];
            query_reg[s][2] = inst_i[s].info.w_reg;
            hz[s] = ((inst_i[s].info.r_reg[0] != REG_ZERO) && query_busy[s][0])
                  | ((inst_i[s].info.r_reg[1] != REG_ZERO) && query_busy[s][1])
                  | ((inst_i[s].info.w_reg    != REG_ZERO) && query_busy[s][2]);
        end
    end

    assign can_accept      = ~valid_q[0] | exe_ready_i;
    assign backend_stall_o = ~can_accept;

    always_comb begin
        raw = (inst_i[0].info.w_reg != REG_ZERO)
            && ((inst_i[1].info.r_reg[0] == inst_i[0].info.w_reg)
             || (inst_i[1].info.r_reg[1] == inst_i[0].info.w_reg));
        waw = (inst_i[0].info.w_reg != REG_ZERO)
            && (inst_i[1].info.w_reg == inst_i[0].info.w_reg);
        pair_ok = ~raw & ~waw
                & ~((cls0 == InstMem) && (cls1 == InstMem))
                & ~((cls0 == InstBr)  && (cls1 == InstBr))
                & (cls0 != InstPriv) & (cls1 != InstPriv);
    end

    // rst gating keeps the combinational pop count at zero during reset.
    assign slot0_iss   = ~rst & inst_valid_i[0] & ~hz[0] & can_accept & ~flush_i;
    assign slot1_iss   = slot0_iss & inst_valid_i[1] & ~hz[1] & pair_ok;
    assign issue_num_o = {slot1_iss, slot0_iss & ~slot1_iss};

    always_comb begin
        set_valid[0] = slot0_iss & is_long_latency(cls0);
        set_valid[1] = slot1_iss & is_long_latency(cls1);
        set_reg[0]   = inst_i[0].info.w_reg;
        set_reg[1]   = inst_i[1].info.w_reg;
    end

    issue_scoreboard #(
        .NUM_WB_PORTS (NUM_WB_PORTS),
        .REG_NUM      (REG_NUM)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .set_valid_i  (set_valid),
        .set_reg_i    (set_reg),
        .wb_valid_i   (wb_valid_i),
        .wb_reg_i     (wb_reg_i),
        .query_reg_i  (query_reg),
        .query_busy_o (query_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q  <= '0;
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (can_accept) begin
            inst_q  <= inst_i;
            valid_q <= {slot1_iss, slot0_iss};
        end
    end

    assign issue_inst_o  = inst_q;
    assign issue_valid_o = valid_q;

`ifdef ISSUE_PERF_CNT_EN
    // Index 0 = dual, 1 = single, 2 = zero issue cycles.
    logic [2:0][31:0] cnt_q;
    logic [2:0]       cnt_inc;

    always_comb begin
        cnt_inc    = '0;
        cnt_inc[0] = inst_valid_i[0] && (issue_num_o == 2'd2);
        cnt_inc[1] = inst_valid_i[0] && (issue_num_o == 2'd1);
        cnt_inc[2] = inst_valid_i[0] && (issue_num_o == 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cnt_inc[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 32'd1;
            end
        end
    end

    assign perf_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed bench for dual_issue_ctrl: pairing rules, scoreboard, stall, flush and async reset.
module tb_dual_issue_ctrl;
    import issue_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    inst_t [1:0]     inst_i;
    logic [1:0]      inst_valid_i;
    logic [1:0]      issue_num_o;
    logic            backend_stall_o;
    logic            flush_i;
    logic            exe_ready_i;
    logic [1:0]      wb_valid_i;
    logic [1:0][4:0] wb_reg_i;
    inst_t [1:0]     issue_inst_o;
    logic [1:0]      issue_valid_o;
`ifdef ISSUE_PERF_CNT_EN
    logic [2:0][31:0] perf_cnt_o;
`endif

    dual_issue_ctrl #(
        .NUM_WB_PORTS (2),
        .REG_NUM      (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_i          (inst_i),
        .inst_valid_i    (inst_valid_i),
        .issue_num_o     (issue_num_o),
        .backend_stall_o (backend_stall_o),
        .flush_i         (flush_i),
        .exe_ready_i     (exe_ready_i),
        .wb_valid_i      (wb_valid_i),
        .wb_reg_i        (wb_reg_i),
        .issue_inst_o    (issue_inst_o),
`ifdef ISSUE_PERF_CNT_EN
        .perf_cnt_o      (perf_cnt_o),
`endif
        .issue_valid_o   (issue_valid_o)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic inst_t mk(input op_t op, input logic [4:0] w, input logic [4:0] r0,
                                 input logic [4:0] r1, input logic [31:0] pc);
        inst_t t;
        t.pc             = pc;
        t.info.op        = op;
        t.info.w_reg     = w;
        t.info.r_reg[0]  = r0;
        t.info.r_reg[1]  = r1;
        return t;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input inst_t s0, input inst_t s1, input logic [1:0] v);
        inst_i[0]    = s0;
        inst_i[1]    = s1;
        inst_valid_i = v;
    endtask

    inst_t nop, add_a, add_b, ld5, add6, add8, ld7, mul7, add9, csr4, add10;
    inst_t ld11, ld12, br_a, jmp_b, add1w, mul3, mul9, use3, use9;

    initial begin
        nop   = '0;
        add_a = mk(OpAdd, 5'd1, 5'd2, 5'd3, 32'h100);
        add_b = mk(OpAdd, 5'd4, 5'd5, 5'd6, 32'h104);
        ld5   = mk(OpLd,  5'd5, 5'd1, 5'd0, 32'h108);
        add6  = mk(OpAdd, 5'd6, 5'd5, 5'd1, 32'h10c);
        add8  = mk(OpAdd, 5'd8, 5'd2, 5'd3, 32'h110);
        ld7   = mk(OpLd,  5'd7, 5'd2, 5'd0, 32'h114);
        mul7  = mk(OpMul, 5'd7, 5'd2, 5'd3, 32'h118);
        add9  = mk(OpAdd, 5'd9, 5'd7, 5'd0, 32'h11c);
        csr4  = mk(OpCsr, 5'd4, 5'd0, 5'd0, 32'h120);
        add10 = mk(OpAdd, 5'd10, 5'd2, 5'd3, 32'h124);
        ld11  = mk(OpLd,  5'd11, 5'd2, 5'd0, 32'h128);
        ld12  = mk(OpLd,  5'd12, 5'd3, 5'd0, 32'h12c);
        br_a  = mk(OpBr,  5'd0, 5'd1, 5'd2, 32'h130);
        jmp_b = mk(OpJmp, 5'd0, 5'd0, 5'd0, 32'h134);
        add1w = mk(OpAdd, 5'd1, 5'd4, 5'd5, 32'h138);
        mul3  = mk(OpMul, 5'd3, 5'd1, 5'd2, 32'h13c);
        mul9  = mk(OpMul, 5'd9, 5'd1, 5'd2, 32'h140);
        use3  = mk(OpAdd, 5'd1, 5'd3, 5'd0, 32'h144);
        use9  = mk(OpAdd, 5'd2, 5'd9, 5'd0, 32'h148);

        rst = 1'b1; flush_i = 1'b0; exe_ready_i = 1'b1;
        wb_valid_i = '0; wb_reg_i = '0;
        put(add_a, add_b, 2'b11);
        #2;
        check("rst_valid", 64'(issue_valid_o), 64'd0);
        check("rst_lane0", 64'(issue_inst_o[0]), 64'd0);
        check("rst_lane1", 64'(issue_inst_o[1]), 64'd0);
        check("rst_stall", 64'(backend_stall_o), 64'd0);
        check("rst_num", 64'(issue_num_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Two independent ADDs pair up.
        #1 check("pair_num", 64'(issue_num_o), 64'd2);
        cyc();
        check("pair_valid", 64'(issue_valid_o), 64'd3);
        check("pair_lane0", 64'(issue_inst_o[0]), 64'(add_a));
        check("pair_lane1", 64'(issue_inst_o[1]), 64'(add_b));

        // LD r5 then dependent ADD: split, then wait for writeback.
        put(ld5, add6, 2'b11);
        #1 check("ld_raw_num", 64'(issue_num_o), 64'd1);
        cyc();
        check("ld_valid", 64'(issue_valid_o), 64'd1);
        check("ld_lane0", 64'(issue_inst_o[0]), 64'(ld5));
        put(add6, nop, 2'b01);
        #1 check("hz_num_a", 64'(issue_num_o), 64'd0);
        cyc();
        check("hz_bubble", 64'(issue_valid_o), 64'd0);
        #1 check("hz_num_b", 64'(issue_num_o), 64'd0);
        cyc();
        wb_valid_i = 2'b01; wb_reg_i[0] = 5'd5;
        #1 check("wb_release", 64'(issue_num_o), 64'd1);
        cyc();
        wb_valid_i = '0;
        check("wb_lane0", 64'(issue_inst_o[0]), 64'(add6));

        // Execute back-pressure holds the latch.
        exe_ready_i = 1'b0;
        put(add8, nop, 2'b01);
        #1 check("stall_on", 64'(backend_stall_o), 64'd1);
        check("stall_num", 64'(issue_num_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_hold", 64'(issue_inst_o[0]), 64'(add6));
            check("stall_hvld", 64'(issue_valid_o), 64'd1);
        end
        exe_ready_i = 1'b1;
        #1 check("stall_off", 64'(backend_stall_o), 64'd0);
        check("resume_num", 64'(issue_num_o), 64'd1);
        cyc();
        check("resume_lane", 64'(issue_inst_o[0]), 64'(add8));

        // Same-cycle clear and set of r7: set wins.
        put(ld7, nop, 2'b01);
        #1 check("ld7_num", 64'(issue_num_o), 64'd1);
        cyc();
        put(mul7, nop, 2'b01);
        wb_valid_i = 2'b01; wb_reg_i[0] = 5'd7;
        #1 check("mul7_num", 64'(issue_num_o), 64'd1);
        cyc();
        wb_valid_i = '0;
        put(add9, nop, 2'b01);
        #1 check("r7_busy", 64'(issue_num_o), 64'd0);
        wb_valid_i = 2'b11; wb_reg_i[0] = 5'd7; wb_reg_i[1] = 5'd7;
        #1 check("r7_dup_wb", 64'(issue_num_o), 64'd1);
        cyc();
        wb_valid_i = '0;

        // Privileged ops issue alone in slot 0.
        put(add_a, csr4, 2'b11);
        #1 check("priv_s1", 64'(issue_num_o), 64'd1);
        cyc();
        put(csr4, add10, 2'b11);
        #1 check("priv_s0", 64'(issue_num_o), 64'd1);
        cyc();
        check("priv_lane0", 64'(issue_inst_o[0]), 64'(csr4));
        check("priv_valid", 64'(issue_valid_o), 64'd1);

        // Structural pairing limits.
        put(ld11, ld12, 2'b11);
        #1 check("mem_pair", 64'(issue_num_o), 64'd1);
        cyc();
        put(br_a, jmp_b, 2'b11);
        #1 check("br_pair", 64'(issue_num_o), 64'd1);
        cyc();
        put(add_a, add1w, 2'b11);
        #1 check("waw_pair", 64'(issue_num_o), 64'd1);
        cyc();

        // Flush with full latch and r3/r9 busy.
        put(mul3, mul9, 2'b11);
        #1 check("mul_pair", 64'(issue_num_o), 64'd2);
        cyc();
        check("pre_flush_v", 64'(issue_valid_o), 64'd3);
        put(use3, use9, 2'b11);
        #1 check("r3_busy", 64'(issue_num_o), 64'd0);
        flush_i = 1'b1;
        #1 check("flush_num", 64'(issue_num_o), 64'd0);
        cyc();
        flush_i = 1'b0;
        check("flush_valid", 64'(issue_valid_o), 64'd0);
        #1 check("sb_cleared", 64'(issue_num_o), 64'd2);
        cyc();
        check("post_flush_v", 64'(issue_valid_o), 64'd3);

        // Asynchronous reset mid-cycle.
        put(add_a, add_b, 2'b11);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(issue_valid_o), 64'd0);
        check("arst_lane0", 64'(issue_inst_o[0]), 64'd0);
        check("arst_num", 64'(issue_num_o), 64'd0);
        check("arst_stall", 64'(backend_stall_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
